// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU load/store port, the host bridge and the data RAM.
// Latency: n/a (signal container only).
// Backpressure: requesters hold req/we/addr/wdata stable until their *_gnt is seen.
//
// Modports:
//   slave  : arbiter side (consumes requests, drives grants, rvalids and RAM pins)
//   master : environment side (requesters and RAM instance)
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // CPU (execute stage) port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  // HOST (debug bridge) port
  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  // shared read return
  logic [DW-1:0] rdata;
  // RAM pins
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_datain;
  logic [DW-1:0] ram_dataout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid,
    output rdata,
    output ram_addr, ram_we, ram_datain,
    input  ram_dataout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid,
    input  rdata,
    input  ram_addr, ram_we, ram_datain,
    output ram_dataout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and the host port.
// Latency: grant is combinational in the request cycle; read data/rvalid one cycle later.
// Backpressure: a denied requester sees no grant (CPU also sees cpu_stall) and must hold its request.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-low reset
//   bus  - dmem_arbiter_if.slave: CPU request/grant/stall/rvalid, HOST request/lock/grant/rvalid,
//          shared rdata, and the RAM addr/we/datain/dataout pins
//
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN to alternate simultaneous grants in
// CPU_PRI instead of fixed CPU priority with starvation relief.
module dmem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,   // 1..15
  parameter int LOCK_MAX     = 8    // 1..15
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    CPU_PRI     = 1'b0,
    HOST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_TOP = 4'(STARVE_LIMIT);
  localparam logic [3:0] LOCK_TOP   = 4'(LOCK_MAX);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_starve_cnt;
  logic [3:0]    w_starve_nxt;
  logic [3:0]    r_lock_cnt;
  logic [3:0]    w_lock_nxt;
  logic          r_cpu_rvalid;
  logic          r_host_rvalid;

  logic          w_cpu_gnt;
  logic          w_host_gnt;
  logic          w_pri_cpu;      // CPU_PRI arbitration result for this cycle
  logic          w_pri_host;
  logic          w_hold_lock;    // host still asking to keep the RAM

  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we;
  logic [DW-1:0] w_ram_datain;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // 1 = CPU took the most recent grant, so HOST wins the next conflict.
  logic          r_rr_last;
`endif

  assign w_hold_lock = bus.host_req & bus.host_lock;

  // CPU_PRI arbitration. Also used for the cycle that leaves HOST_LOCKED.
  always_comb begin
    w_pri_cpu  = 1'b0;
    w_pri_host = 1'b0;
    if (bus.cpu_req && bus.host_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (r_rr_last) begin
        w_pri_host = 1'b1;
      end else begin
        w_pri_cpu  = 1'b1;
      end
`else
      if (r_starve_cnt >= STARVE_TOP) begin
        w_pri_host = 1'b1;
      end else begin
        w_pri_cpu  = 1'b1;
      end
`endif
    end else begin
      w_pri_cpu  = bus.cpu_req;
      w_pri_host = bus.host_req;
    end
  end

  // FSM next-state, grants and lock counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    w_lock_nxt  = r_lock_cnt;
    case (r_state)
      CPU_PRI: begin
        w_cpu_gnt  = w_pri_cpu;
        w_host_gnt = w_pri_host;
        // The entering grant is the first locked grant of the burst.
        if (w_pri_host && bus.host_lock) begin
          w_state_nxt = HOST_LOCKED;
          w_lock_nxt  = 4'd1;
        end else begin
          w_lock_nxt  = 4'd0;
        end
      end
      HOST_LOCKED: begin
        if (w_hold_lock) begin
          if ((r_lock_cnt >= LOCK_TOP) && bus.cpu_req) begin
            // Forced CPU slot; the lock survives and the count restarts.
            w_cpu_gnt  = 1'b1;
            w_lock_nxt = 4'd0;
          end else begin
            // Count saturates at LOCK_MAX while the CPU is idle.
            w_host_gnt = 1'b1;
            if (r_lock_cnt < LOCK_TOP) begin
              w_lock_nxt = r_lock_cnt + 4'd1;
            end
          end
        end else begin
          // Release cycle is arbitrated normally.
          w_cpu_gnt   = w_pri_cpu;
          w_host_gnt  = w_pri_host;
          w_state_nxt = CPU_PRI;
          w_lock_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = CPU_PRI;
        w_lock_nxt  = 4'd0;
      end
    endcase
    // No RAM access is performed while reset is asserted.
    if (!rst) begin
      w_cpu_gnt  = 1'b0;
      w_host_gnt = 1'b0;
    end
  end

  // Starvation counter: counts consecutive denied HOST cycles.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!bus.host_req || w_host_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < STARVE_TOP) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= CPU_PRI;
      r_starve_cnt  <= 4'd0;
      r_lock_cnt    <= 4'd0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_starve_cnt  <= w_starve_nxt;
      r_lock_cnt    <= w_lock_nxt;
      r_cpu_rvalid  <= w_cpu_gnt & ~bus.cpu_we;
      r_host_rvalid <= w_host_gnt & ~bus.host_we;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_last <= 1'b0;
    end else if (w_cpu_gnt || w_host_gnt) begin
      r_rr_last <= w_cpu_gnt;
    end
  end
`endif

  // RAM mux: idle pins are driven to zero so the RAM sees no stray writes.
  always_comb begin
    w_ram_addr   = '0;
    w_ram_we     = 1'b0;
    w_ram_datain = '0;
    if (w_cpu_gnt) begin
      w_ram_addr   = bus.cpu_addr;
      w_ram_we     = bus.cpu_we;
      w_ram_datain = bus.cpu_wdata;
    end else if (w_host_gnt) begin
      w_ram_addr   = bus.host_addr;
      w_ram_we     = bus.host_we;
      w_ram_datain = bus.host_wdata;
    end
  end

  assign bus.ram_addr    = w_ram_addr;
  assign bus.ram_we      = w_ram_we;
  assign bus.ram_datain  = w_ram_datain;

  assign bus.cpu_gnt     = w_cpu_gnt;
  assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt;
  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  // RAM output register already holds the last read; a write issued now does not touch it.
  assign bus.rdata       = bus.ram_dataout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single-cycle vectors plus multi-cycle
// sequences (starvation, reset, lock burst, round robin), with a read-data scoreboard.
module tb_dmem_arbiter;

  logic clk;
  logic rst;

  dmem_arbiter_if #(.AW(10), .DW(32)) bus ();

  dmem_arbiter #(
    .AW(10), .DW(32), .STARVE_LIMIT(4), .LOCK_MAX(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: single port, 1-cycle read latency, output register untouched by writes.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_datain;
    else            bus.ram_dataout  <= mem[bus.ram_addr];
  end

  typedef struct {
    logic        cr;
    logic        cwe;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        hr;
    logic        hwe;
    logic        hl;
    logic [9:0]  ha;
    logic [31:0] hd;
    byte         g;      // expected grant: "c", "h" or "-"
  } vec_t;

  typedef struct {
    bit          is_host;
    logic [31:0] data;
  } rd_t;

  rd_t         sb[$];
  logic [31:0] shadow [0:1023];
  int          n_pass;
  int          n_total;
  int          n_hrv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else             n_pass++;
  endtask

  function automatic vec_t mk(input logic cr, input logic cwe, input logic [9:0] ca,
                              input logic [31:0] cd, input logic hr, input logic hwe,
                              input logic hl, input logic [9:0] ha, input logic [31:0] hd,
                              input byte g);
    vec_t v;
    v.cr = cr; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hwe = hwe; v.hl = hl; v.ha = ha; v.hd = hd;
    v.g  = g;
    return v;
  endfunction

  // One clock: drive after the falling edge, check 1 ns later, return at the next falling edge.
  task automatic cycle(input logic r, input vec_t v, input string tag);
    logic        ec, eh, ewe;
    logic [9:0]  ea;
    logic [31:0] ed;
    bit          ecrv, ehrv;
    rd_t         e;
    rst            = r;
    bus.cpu_req    = v.cr;  bus.cpu_we  = v.cwe; bus.cpu_addr  = v.ca; bus.cpu_wdata  = v.cd;
    bus.host_req   = v.hr;  bus.host_we = v.hwe; bus.host_lock = v.hl;
    bus.host_addr  = v.ha;  bus.host_wdata = v.hd;
    #1;
    // Read return for the previous cycle's grant.
    ecrv = (sb.size() > 0) && !sb[0].is_host;
    ehrv = (sb.size() > 0) &&  sb[0].is_host;
    chk({tag, ".cpu_rvalid"},  {31'd0, bus.cpu_rvalid},  {31'd0, ecrv});
    chk({tag, ".host_rvalid"}, {31'd0, bus.host_rvalid}, {31'd0, ehrv});
    if (bus.host_rvalid === 1'b1) n_hrv++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rdata"}, bus.rdata, e.data);
    end
    // Grant and RAM mux for this cycle.
    ec = (v.g == "c");
    eh = (v.g == "h");
    chk({tag, ".cpu_gnt"},   {31'd0, bus.cpu_gnt},   {31'd0, ec});
    chk({tag, ".host_gnt"},  {31'd0, bus.host_gnt},  {31'd0, eh});
    chk({tag, ".cpu_stall"}, {31'd0, bus.cpu_stall}, {31'd0, v.cr & ~ec});
    ea = 10'd0; ewe = 1'b0; ed = 32'd0;
    if (ec)      begin ea = v.ca; ewe = v.cwe; ed = v.cd; end
    else if (eh) begin ea = v.ha; ewe = v.hwe; ed = v.hd; end
    chk({tag, ".ram_addr"},   {22'd0, bus.ram_addr}, {22'd0, ea});
    chk({tag, ".ram_we"},     {31'd0, bus.ram_we},   {31'd0, ewe});
    chk({tag, ".ram_datain"}, bus.ram_datain,        ed);
    if (ec || eh) begin
      if (ewe) shadow[ea] = ed;
      else begin
        e.is_host = eh;
        e.data    = shadow[ea];
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  vec_t  vt[14];
  vec_t  idle;
  vec_t  both;
  vec_t  v;
  string pat;
  int    idx;

  initial begin
    n_pass = 0; n_total = 0; n_hrv = 0;
    idle = mk(0, 0, 10'h000, 32'h0, 0, 0, 0, 10'h000, 32'h0, "-");
    both = mk(1, 0, 10'h005, 32'h0, 1, 0, 0, 10'h3FF, 32'h0, "-");

    //            cr cwe ca       cd            hr hwe hl ha       hd            g
    vt[0]  = mk(0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        "-");
    vt[1]  = mk(1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 0, 10'h000, 32'h0,        "c");
    vt[2]  = mk(1, 0, 10'h005, 32'h0,        0, 0, 0, 10'h000, 32'h0,        "c");
    vt[3]  = mk(0, 0, 10'h000, 32'h0,        1, 1, 0, 10'h3FF, 32'h12345678, "h");
    vt[4]  = mk(1, 1, 10'h020, 32'h0BADF00D, 1, 0, 0, 10'h3FF, 32'h0,        "c");
    vt[5]  = mk(0, 0, 10'h000, 32'h0,        1, 0, 0, 10'h3FF, 32'h0,        "h");
    vt[6]  = mk(0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        "-");
    vt[7]  = mk(0, 0, 10'h000, 32'h0,        1, 1, 0, 10'h010, 32'h0000A5A5, "h");
    vt[8]  = mk(1, 0, 10'h010, 32'h0,        1, 1, 0, 10'h011, 32'h5A5A0000, "c");
    vt[9]  = mk(0, 0, 10'h000, 32'h0,        1, 1, 0, 10'h011, 32'h5A5A0000, "h");
    vt[10] = mk(1, 0, 10'h020, 32'h0,        0, 0, 0, 10'h000, 32'h0,        "c");
    vt[11] = mk(0, 0, 10'h000, 32'h0,        1, 0, 0, 10'h011, 32'h0,        "h");
    vt[12] = mk(1, 0, 10'h3FF, 32'h0,        1, 0, 0, 10'h010, 32'h0,        "c");
    vt[13] = mk(0, 0, 10'h000, 32'h0,        1, 0, 0, 10'h010, 32'h0,        "h");

    // Reset state.
    rst = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_lock = 0; bus.host_addr = '0; bus.host_wdata = '0;
    @(negedge clk);
    v = idle; v.cr = 1'b1; v.hr = 1'b1;   // requests during reset are never granted
    cycle(0, v, "reset");
    cycle(1, idle, "idle");

    for (int i = 0; i < 14; i++) cycle(1, vt[i], $sformatf("vec%0d", i));
    cycle(1, idle, "drain");

    // Preload the lock-burst addresses through the host port.
    for (int i = 0; i < 12; i++)
      cycle(1, mk(0, 0, 10'h0, 32'h0, 1, 1, 0, 10'h100 + 10'(i), 32'hC0DE0000 + i, "h"), "prewr");

`ifndef DMEM_ARB_ROUND_ROBIN_EN
    cycle(1, idle, "st_idle");
    pat = "cccchcccch";
    for (int i = 0; i < pat.len(); i++) begin
      v = both; v.g = pat[i];
      cycle(1, v, $sformatf("starve%0d", i));
    end
`else
    cycle(0, idle, "rr_rst");
    pat = "chchch";
    for (int i = 0; i < pat.len(); i++) begin
      v = both; v.g = pat[i];
      cycle(1, v, $sformatf("rr%0d", i));
    end
`endif

    // Reset in the middle of a conflict run, while a CPU load is being requested.
    cycle(1, idle, "rs_idle");
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    pat = "ccc";
`else
    pat = "chc";
`endif
    for (int i = 0; i < pat.len(); i++) begin
      v = both; v.g = pat[i];
      cycle(1, v, $sformatf("pre_rst%0d", i));
    end
    v = both; v.g = "-";
    cycle(0, v, "in_rst");
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    pat = "cccch";
`else
    pat = "ch";
`endif
    for (int i = 0; i < pat.len(); i++) begin
      v = both; v.g = pat[i];
      cycle(1, v, $sformatf("post_rst%0d", i));
    end

    // Lock burst of 12 host reads against a held CPU load.
    cycle(1, idle, "lk_idle");
    n_hrv = 0;
    cycle(1, mk(0, 0, 10'h005, 32'h0, 1, 0, 1, 10'h100, 32'h0, "h"), "lock0");
    idx = 1;
    pat = "hhhhhhhchhhh";
    for (int i = 0; i < pat.len(); i++) begin
      v = mk(1, 0, 10'h005, 32'h0, 1, 0, 1, 10'h100 + 10'(idx), 32'h0, pat[i]);
      cycle(1, v, $sformatf("lock%0d", i + 1));
      if (pat[i] == "h") idx++;
    end
    cycle(1, mk(1, 0, 10'h005, 32'h0, 0, 0, 0, 10'h000, 32'h0, "c"), "unlock");
    cycle(1, idle, "lk_drain");
    chk("lock.host_rvalid_count", n_hrv, 32'd12);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
